vdot_unit: RTL and testbench

Multi-cycle execution unit for the custom VDOT instruction (opcode 7'b0101011), in the EX stage directly downstream of the control unit. On a decoded VDOT issue it latches two 32-bit register operands, each holding LANES packed signed elements, and computes their dot product with one multiply-accumulate per cycle. It stalls the pipeline while busy and returns the 32-bit result with its destination register for writeback.

---
 rtl/vdot_unit.sv | 152 +++++++++++++++
 tb/tb_vdot_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/vdot_unit.sv
// vdot_unit: multi-cycle signed dot-product unit for the VDOT instruction.
// It latches two packed operands and processes one lane multiply-accumulate
// per cycle. The result and its destination register are returned for writeback.
// Optional feature macro: VDOT_ACC_EN. When it is defined, the accumulator is
// seeded from acc_in. When it is undefined, the accumulator is seeded with zero.
module vdot_unit #(
  parameter int LANES  = 4,
  parameter int ELEM_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        flush,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  rd_in,
  input  logic [31:0] acc_in,
  output logic        busy,
  output logic        res_valid,
  output logic [31:0] res,
  output logic [4:0]  res_rd
);

  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic [31:0]         acc_q,   acc_d;
  logic [31:0]         op_a_q,  op_a_d;
  logic [31:0]         op_b_q,  op_b_d;
  logic [4:0]          rd_q,    rd_d;

  logic [31:0]                 sh_a_s;
  logic [31:0]                 sh_b_s;
  logic signed [ELEM_W-1:0]    lane_a_s;
  logic signed [ELEM_W-1:0]    lane_b_s;
  logic signed [2*ELEM_W-1:0]  prod_s;
  logic signed [31:0]          prod_ext_s;
  logic [31:0]                 seed_s;

  // Select the current lane of each operand and form its sign-extended product.
  always_comb begin
    sh_a_s     = op_a_q >> (cnt_q * ELEM_W);
    sh_b_s     = op_b_q >> (cnt_q * ELEM_W);
    lane_a_s   = sh_a_s[ELEM_W-1:0];
    lane_b_s   = sh_b_s[ELEM_W-1:0];
    prod_s     = (2*ELEM_W)'(lane_a_s) * (2*ELEM_W)'(lane_b_s);
    prod_ext_s = 32'(prod_s);
  end

  // Pick the accumulator seed loaded when an issue is accepted.
  always_comb begin
`ifdef VDOT_ACC_EN
    seed_s = acc_in;
`else
    // acc_in stays wired for the accumulating variant; it is masked off here.
    seed_s = acc_in & 32'h0000_0000;
`endif
  end

  // Next-state logic: issue acceptance, per-lane MAC, completion and flush.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    rd_d    = rd_q;
    if (flush) begin
      // Abort: return to IDLE without touching the accumulator.
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_MAC;
            cnt_d   = '0;
            acc_d   = seed_s;
            op_a_d  = op_a;
            op_b_d  = op_b;
            rd_d    = rd_in;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_MAC: begin
          // Issues arriving here are ignored; the pipeline is stalled.
          acc_d = acc_q + prod_ext_s;
          if (cnt_q == LAST_LANE) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (start) begin
            // Back-to-back issue: old result stays visible this cycle.
            state_d = ST_MAC;
            cnt_d   = '0;
            acc_d   = seed_s;
            op_a_d  = op_a;
            op_b_d  = op_b;
            rd_d    = rd_in;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= 32'd0;
      op_a_q  <= 32'd0;
      op_b_q  <= 32'd0;
      rd_q    <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      rd_q    <= rd_d;
    end
  end

  // Outputs: the stall is decoded from state, and flush suppresses the strobe in DONE.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    res_valid = (state_q == ST_DONE) && !flush;
    res       = acc_q;
    res_rd    = rd_q;
  end

endmodule

// File: tb/tb_vdot_unit.sv
// Scoreboard bench for vdot_unit: directed test-plan vectors plus random issues.
// The reference model computes dot products lane by lane with integer arithmetic.
module tb_vdot_unit;

  localparam int LANES = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic [4:0]  rd_in = 5'd0;
  logic [31:0] acc_in = 32'd0;
  logic        busy;
  logic        res_valid;
  logic [31:0] res;
  logic [4:0]  res_rd;

  vdot_unit #(.LANES(4), .ELEM_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .acc_in(acc_in),
    .busy(busy), .res_valid(res_valid), .res(res), .res_rd(res_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: signed lane products summed modulo 2^32.
  function automatic logic [31:0] ref_dot(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] seed);
    int  sum;
    byte ea;
    byte eb;
    sum = int'(seed);
    for (int k = 0; k < LANES; k++) begin
      ea  = a[k*8 +: 8];
      eb  = b[k*8 +: 8];
      sum = sum + int'(ea) * int'(eb);
    end
    return 32'(sum);
  endfunction

  // Drive one issue for a cycle; push the expected result if it should retire.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] seed, input bit expect_res);
    exp_t e;
    logic [31:0] eff_seed;
`ifdef VDOT_ACC_EN
    eff_seed = seed;
`else
    eff_seed = 32'd0;
`endif
    start = 1'b1; op_a = a; op_b = b; rd_in = rd; acc_in = seed;
    @(posedge clk); #1;
    start = 1'b0;
    op_a = $urandom; op_b = $urandom; acc_in = $urandom;
    if (expect_res) begin
      e.res = ref_dot(a, b, eff_seed);
      e.rd  = rd;
      e.due = cyc + LANES;
      sb_q.push_back(e);
    end
  endtask

  // Step through the MAC cycles up to DONE, checking the stall and optionally poking start.
  task automatic run_to_done(input bit poke);
    for (int i = 0; i < LANES; i++) begin
      check("busy_mac", {31'd0, busy}, 32'd1);
      if (poke && i == 1) begin
        start = 1'b1; rd_in = 5'($urandom);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("busy_done", {31'd0, busy}, 32'd1);
  endtask

  // Monitor: pop and compare whenever the unit presents a writeback.
  always @(negedge clk) begin
    if (res_valid) begin
      if (sb_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_valid: got res=%h rd=%0d, expected no strobe (cycle %0d)", res, res_rd, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("res", res, e.res);
        check("res_rd", {27'd0, res_rd}, {27'd0, e.rd});
        check("latency", 32'(cyc), 32'(e.due));
      end
    end else if (sb_q.size() > 0 && cyc > sb_q[0].due) begin
      exp_t e;
      e = sb_q.pop_front();
      n_tests++; n_fail++;
      $display("FAIL missing_valid: got no strobe, expected res=%h by cycle %0d", e.res, e.due);
    end
  end

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res", res, 32'd0);
    check("rst_rd", {27'd0, res_rd}, 32'd0);
    @(posedge clk); #1;

    // Basic, with an ignored start poked during MAC.
    check("busy_idle", {31'd0, busy}, 32'd0);
    issue(32'h01020304, 32'h01010101, 5'd5, 32'd100, 1'b1);
    run_to_done(1'b1);
    @(posedge clk); #1;
    check("busy_after", {31'd0, busy}, 32'd0);

    // Sign cases.
    issue(32'hFFFFFFFF, 32'h02020202, 5'd7, 32'd0, 1'b1);
    run_to_done(1'b0);
    @(posedge clk); #1;
    issue(32'h80808080, 32'h80808080, 5'd31, 32'hFFFF_0000, 1'b1);
    run_to_done(1'b0);

    // Back-to-back from DONE.
    issue(32'h02020202, 32'h03030303, 5'd9, 32'd7, 1'b1);
    run_to_done(1'b0);
    check("res_hold", res, ref_dot(32'h02020202, 32'h03030303,
`ifdef VDOT_ACC_EN
                                   32'd7
`else
                                   32'd0
`endif
                                   ));
    @(posedge clk); #1;

    // Flush at T+2.
    issue(32'h11223344, 32'h55667788, 5'd3, 32'd0, 1'b0);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    repeat (6) @(posedge clk);
    #1;

    // Flush in DONE, with a simultaneous start that must be dropped.
    issue(32'h01010101, 32'h01010101, 5'd4, 32'd0, 1'b0);
    run_to_done(1'b0);
    flush = 1'b1; start = 1'b1;
    #1;
    check("flush_done_valid", {31'd0, res_valid}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    check("flush_done_busy", {31'd0, busy}, 32'd0);
    repeat (6) @(posedge clk);
    #1;

    // Reset mid-operation at T+3.
    issue(32'h7F7F7F7F, 32'h7F7F7F7F, 5'd12, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_res", res, 32'd0);
    check("rstmid_rd", {27'd0, res_rd}, 32'd0);
    repeat (6) @(posedge clk);
    #1;

    // Random issues, mixing idle gaps and back-to-back starts.
    for (int n = 0; n < 40; n++) begin
      issue($urandom, $urandom, 5'($urandom), $urandom, 1'b1);
      run_to_done(n[0]);
      if ($urandom_range(0, 2) != 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        check("busy_gap", {31'd0, busy}, 32'd0);
      end
    end

    // Drain with a bounded wait.
    for (int w = 0; w < 20 && sb_q.size() > 0; w++) @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain: got %0d pending results, expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
